nibble_serial_adder_ctrl: RTL
=============================

# nibble_serial_adder_ctrl

Sequencing controller that performs a 4*WORDS-bit addition by streaming operands, one nibble per cycle, through the existing combinational 4-bit `n_ripple_adder`. It sits directly upstream and downstream of that adder. It drives the adder's `a`, `b` and `c_in`, and captures the adder's `sum` and `c_out`, feeding `c_out` back as the next nibble's carry-in. Operands arrive and results leave through valid/ready handshakes.

## Interface
Parameters:
- WORDS, default 4: number of 4-bit slices, must be at least 1; operand width is W = 4*WORDS.

Ports:
- clk  in  1  single clock for the block; all state updates on its rising edge
- rst  in  1  reset, asynchronous and active-high
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- op_a  in  W  operand A
- op_b  in  W  operand B
- op_cin  in  1  initial carry-in
- add_a  out  4  to adder `a`
- add_b  out  4  to adder `b`
- add_cin  out  1  to adder `c_in`
- add_sum  in  4  from adder `sum`
- add_cout  in  1  from adder `c_out`
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  W  sum
- result_cout  out  1  unsigned carry out of the top nibble
- overflow  out  1  two's-complement overflow

## Operation
- FSM states: IDLE, ADD, DONE.
- **IDLE**
  - in_ready=1; add_a=0, add_b=0, add_cin=0.
  - Accept edge (in_valid & in_ready) performs all of:
    - latch op_a and op_b into shift registers;
    - carry_reg <= op_cin;
    - latch sa=op_a[W-1] and sb=op_b[W-1];
    - idx <= 0;
    - go to ADD.
- **ADD**
  - in_ready=0.
  - add_a = a_sh[3:0], add_b = b_sh[3:0], add_cin = carry_reg.
  - Each edge performs all of:
    - res_sh <= {add_sum, res_sh[W-1:4]};
    - carry_reg <= add_cout;
    - a_sh and b_sh shift right by 4;
    - idx <= idx+1.
  - When idx==WORDS-1 at an edge, go to DONE. The adder is purely combinational, so each nibble completes within one cycle.
- **DONE**
  - out_valid=1, in_ready=0; adder inputs driven 0.
  - Outputs:
    - result = res_sh;
    - result_cout = carry_reg;
    - overflow = (sa==sb) & (result[W-1]!=sa).
  - On an out_valid & out_ready edge, go to IDLE.
- Arithmetic is modulo 2^W. {result_cout, result} = op_a + op_b + op_cin exactly.
- Reset values: state IDLE, all registers 0. Hence in_ready=1 during and after reset, and out_valid=0, result=0, result_cout=0, overflow=0, add_a=0, add_b=0, add_cin=0.
- Boundary conditions:
  - Reset asserted in any state, including mid-ADD: the operation is aborted immediately, no out_valid is ever produced for it, and all outputs return to their reset values.
  - in_valid while in ADD or DONE: ignored, not queued; the source must hold its operands until in_ready.
  - out_ready already high on entry to DONE: out_valid lasts exactly one cycle.
  - out_ready held low: DONE persists indefinitely; result, result_cout and overflow stay stable.
  - WORDS=1: a single ADD cycle; behaviour is otherwise identical.
  - result is defined only while out_valid=1. It may change during ADD.

## Timing
- Accept edge at cycle 0. ADD occupies cycles 1..WORDS. out_valid rises after edge WORDS, which is 4 cycles for the default WORDS.
- Minimum occupancy per operation is WORDS+2 cycles (IDLE accept, WORDS ADD cycles, 1 DONE cycle). The next accept can happen no earlier than the cycle after the out handshake.
- in_ready and out_valid are decoded combinationally from state only, so there is no combinational path from in_valid or out_ready.
- add_a, add_b and add_cin come from registers plus a mux on state. There is no combinational path from add_sum or add_cout to any output.

## Test plan
All scenarios use WORDS=4 unless stated.
- 0x000F + 0x0008, cin=0 -> result 0x0017, cout=0, ovf=0, out_valid asserted exactly 4 cycles after the accept edge; add_cin=1 is observed on the second nibble.
- 0xFFFF + 0x0001, cin=0 -> result 0x0000, cout=1, ovf=0; add_cin=1 on nibbles 2-4 (full ripple).
- 0x7FFF + 0x0001 -> 0x8000, cout=0, ovf=1; then 0x8000 + 0x8000 with cin=1 -> 0x0001, cout=1, ovf=1.
- Hold out_ready=0 for 10 cycles after out_valid, while in_valid=1 with new operands -> result, cout and ovf stay stable, in_ready=0, the new operands are not accepted. Release out_ready -> IDLE, the new operands are accepted the next cycle, and their result is correct.
- Assert rst asynchronously (mid-cycle) during the 2nd ADD cycle -> outputs go to reset values without waiting for an edge, and no out_valid appears. After deassertion, 0x1234 + 0x4321 -> 0x5555.
- WORDS=1: 0xF + 0x8, cin=0 -> result 0x7, cout=1, ovf=1, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencing controller that streams a 4*WORDS-bit addition through an external
// combinational 4-bit adder, one nibble per cycle, with valid/ready at both ends.
module nibble_serial_adder_ctrl #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WORDS-1:0] op_a,
  input  logic [4*WORDS-1:0] op_b,
  input  logic               op_cin,
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  output logic               add_cin,
  input  logic [3:0]         add_sum,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WORDS-1:0] result,
  output logic               result_cout,
  output logic               overflow
);

  localparam int W     = 4 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  state_e           state_q;
  logic [W-1:0]     a_sh_q;
  logic [W-1:0]     b_sh_q;
  logic [W-1:0]     res_sh_q;
  logic             carry_q;
  logic             sa_q;
  logic             sb_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     res_sh_d;

  // Each adder sum nibble enters at the top so the low nibble ends up at bit 0.
  generate
    if (WORDS == 1) begin : g_single
      assign res_sh_d = add_sum;
    end else begin : g_multi
      assign res_sh_d = {add_sum, res_sh_q[W-1:4]};
    end
  endgenerate

  // NOTE: the datapath shifters are reset along with the FSM so an aborted add
  // leaves the result outputs at zero rather than holding partial sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= op_a;
            b_sh_q  <= op_b;
            carry_q <= op_cin;
            sa_q    <= op_a[W-1];
            sb_q    <= op_b[W-1];
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          res_sh_q <= res_sh_d;
          carry_q  <= add_cout;
          a_sh_q   <= a_sh_q >> 4;
          b_sh_q   <= b_sh_q >> 4;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags depend on state only: no path from in_valid or out_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  assign add_a   = (state_q == ADD) ? a_sh_q[3:0] : 4'h0;
  assign add_b   = (state_q == ADD) ? b_sh_q[3:0] : 4'h0;
  assign add_cin = (state_q == ADD) ? carry_q     : 1'b0;

  assign result      = res_sh_q;
  assign result_cout = carry_q;
  assign overflow    = (sa_q == sb_q) & (res_sh_q[W-1] != sa_q);

endmodule
